// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: redirect-kind encoding and default vectors
// used by the fetch PC, the hazard unit and CP0.
package pipe_pkg;

   localparam int unsigned INSTR_BYTES_DEF = 4;
   localparam logic [31:0] EXC_VECTOR_DEF  = 32'h0000_0180;

   typedef enum logic [1:0] {
      REDIRECT_NONE = 2'd0,
      REDIRECT_JMP  = 2'd1,
      REDIRECT_BR   = 2'd2
   } redirect_kind_e;

   typedef enum logic {
      HOLD_IDLE = 1'b0,
      HOLD_HELD = 1'b1
   } hold_state_e;

endpackage

// File: rtl/pc_redirect_hold.sv
// Pending-redirect register for the fetch PC: captures jump/branch requests
// that arrive during a stall and holds them until the stall releases.
module pc_redirect_hold
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_SIZE = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall,
   input  logic                 exc,
   input  logic                 br_taken,
   input  logic [DATA_SIZE-1:0] br_target,
   input  logic                 jmp,
   input  logic [DATA_SIZE-1:0] jmp_target,
   output logic                 pend_valid,
   output logic [DATA_SIZE-1:0] pend_target
);

   hold_state_e          state_q, state_d;
   redirect_kind_e       kind_q, kind_d;
   logic [DATA_SIZE-1:0] target_q, target_d;

   // Any unstalled edge consumes the entry (applied or squashed by a newer branch).
   always_comb begin
      state_d  = state_q;
      kind_d   = kind_q;
      target_d = target_q;
      if (exc || !stall) begin
         state_d  = HOLD_IDLE;
         kind_d   = REDIRECT_NONE;
         target_d = '0;
      end else if (br_taken) begin
         state_d  = HOLD_HELD;
         kind_d   = REDIRECT_BR;
         target_d = br_target;
      end else if (jmp && (kind_q != REDIRECT_BR)) begin
         state_d  = HOLD_HELD;
         kind_d   = REDIRECT_JMP;
         target_d = jmp_target;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= HOLD_IDLE;
         kind_q   <= REDIRECT_NONE;
         target_q <= '0;
      end else begin
         state_q  <= state_d;
         kind_q   <= kind_d;
         target_q <= target_d;
      end
   end

   assign pend_valid  = (state_q == HOLD_HELD);
   assign pend_target = target_q;

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: priority mux of exception, branch, pending,
// jump and sequential sources, with stall hold and target alignment check.
module pc_unit
   import pipe_pkg::*;
#(
   parameter int unsigned          DATA_SIZE    = 32,
   parameter int unsigned          INSTR_BYTES  = INSTR_BYTES_DEF,
   parameter logic [DATA_SIZE-1:0] RESET_VECTOR = '0,
   parameter logic [DATA_SIZE-1:0] EXC_VECTOR   = DATA_SIZE'(EXC_VECTOR_DEF)
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 STALL,
   input  logic                 JMP,
   input  logic [DATA_SIZE-1:0] JMP_TARGET,
   input  logic                 BR_TAKEN,
   input  logic [DATA_SIZE-1:0] BR_TARGET,
   input  logic                 EXC,
   output logic [DATA_SIZE-1:0] PC_out,
   output logic [DATA_SIZE-1:0] PC_plus,
   output logic                 PC_valid,
   output logic                 REDIRECT,
   output logic                 MISALIGN,
   output logic                 PENDING
);

   localparam logic [DATA_SIZE-1:0] INCR       = DATA_SIZE'(INSTR_BYTES);
   localparam logic [DATA_SIZE-1:0] ALIGN_MASK = DATA_SIZE'(INSTR_BYTES - 1);

   logic [DATA_SIZE-1:0] pc_q, pc_d;
   logic                 valid_q, valid_d;
   logic                 redirect_q, redirect_d;
   logic                 misalign_q, misalign_d;
   logic                 pend_valid;
   logic [DATA_SIZE-1:0] pend_target;
   logic                 take_target;
   logic [DATA_SIZE-1:0] target;

   pc_redirect_hold #(
      .DATA_SIZE (DATA_SIZE)
   ) u_hold (
      .clk         (CLK),
      .rst         (RST),
      .stall       (STALL),
      .exc         (EXC),
      .br_taken    (BR_TAKEN),
      .br_target   (BR_TARGET),
      .jmp         (JMP),
      .jmp_target  (JMP_TARGET),
      .pend_valid  (pend_valid),
      .pend_target (pend_target)
   );

   // The first edge out of reset holds RESET_VECTOR instead of incrementing.
   always_comb begin
      pc_d        = pc_q;
      valid_d     = 1'b1;
      redirect_d  = 1'b0;
      misalign_d  = 1'b0;
      take_target = 1'b0;
      target      = pc_q;
      if (EXC) begin
         pc_d       = EXC_VECTOR;
         redirect_d = 1'b1;
      end else if (!STALL) begin
         if (BR_TAKEN) begin
            take_target = 1'b1;
            target      = BR_TARGET;
         end else if (pend_valid) begin
            take_target = 1'b1;
            target      = pend_target;
         end else if (JMP) begin
            take_target = 1'b1;
            target      = JMP_TARGET;
         end else if (valid_q) begin
            pc_d = pc_q + INCR;
         end
         if (take_target) begin
            redirect_d = 1'b1;
            if ((target & ALIGN_MASK) != '0) begin
               pc_d       = EXC_VECTOR;
               misalign_d = 1'b1;
            end else begin
               pc_d = target;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         pc_q       <= RESET_VECTOR;
         valid_q    <= 1'b0;
         redirect_q <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         valid_q    <= valid_d;
         redirect_q <= redirect_d;
         misalign_q <= misalign_d;
      end
   end

   assign PC_out   = pc_q;
   assign PC_plus  = pc_q + INCR;
   assign PC_valid = valid_q;
   assign REDIRECT = redirect_q;
   assign MISALIGN = misalign_q;
   assign PENDING  = pend_valid;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a 32-bit instance for the main behaviour and
// an 8-bit instance for the address wrap.
module tb_pc_unit;

   logic        CLK = 1'b0;
   logic        RST, STALL, JMP, BR_TAKEN, EXC;
   logic [31:0] JMP_TARGET, BR_TARGET;
   logic [31:0] PC_out, PC_plus;
   logic        PC_valid, REDIRECT, MISALIGN, PENDING;

   logic        rst8, stall8, jmp8, br8, exc8;
   logic [7:0]  jmp_target8, br_target8;
   logic [7:0]  pc8, pc_plus8;
   logic        valid8, redirect8, misalign8, pending8;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 CLK = ~CLK;

   pc_unit u_dut (
      .CLK        (CLK),
      .RST        (RST),
      .STALL      (STALL),
      .JMP        (JMP),
      .JMP_TARGET (JMP_TARGET),
      .BR_TAKEN   (BR_TAKEN),
      .BR_TARGET  (BR_TARGET),
      .EXC        (EXC),
      .PC_out     (PC_out),
      .PC_plus    (PC_plus),
      .PC_valid   (PC_valid),
      .REDIRECT   (REDIRECT),
      .MISALIGN   (MISALIGN),
      .PENDING    (PENDING)
   );

   pc_unit #(
      .DATA_SIZE    (8),
      .INSTR_BYTES  (4),
      .RESET_VECTOR (8'h00),
      .EXC_VECTOR   (8'h80)
   ) u_dut8 (
      .CLK        (CLK),
      .RST        (rst8),
      .STALL      (stall8),
      .JMP        (jmp8),
      .JMP_TARGET (jmp_target8),
      .BR_TAKEN   (br8),
      .BR_TARGET  (br_target8),
      .EXC        (exc8),
      .PC_out     (pc8),
      .PC_plus    (pc_plus8),
      .PC_valid   (valid8),
      .REDIRECT   (redirect8),
      .MISALIGN   (misalign8),
      .PENDING    (pending8)
   );

   task automatic applyStimulus();
      @(posedge CLK);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      tests_run++;
      assert (observed === expected)
      else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic checkState(input string tag, input logic [31:0] pc, input logic pend,
                             input logic redir, input logic mis);
      checkOutput({tag, ".pc"}, PC_out, pc);
      checkOutput({tag, ".pending"}, {31'd0, PENDING}, {31'd0, pend});
      checkOutput({tag, ".redirect"}, {31'd0, REDIRECT}, {31'd0, redir});
      checkOutput({tag, ".misalign"}, {31'd0, MISALIGN}, {31'd0, mis});
   endtask

   initial begin
      RST = 1'b1; STALL = 1'b0; JMP = 1'b0; BR_TAKEN = 1'b0; EXC = 1'b0;
      JMP_TARGET = '0; BR_TARGET = '0;
      rst8 = 1'b1; stall8 = 1'b0; jmp8 = 1'b0; br8 = 1'b0; exc8 = 1'b0;
      jmp_target8 = '0; br_target8 = '0;

      // Reset and sequential run
      applyStimulus();
      applyStimulus();
      checkState("reset", 32'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("reset.valid", {31'd0, PC_valid}, 32'd0);
      RST = 1'b0;
      applyStimulus();
      checkState("first", 32'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("first.valid", {31'd0, PC_valid}, 32'd1);
      checkOutput("first.plus", PC_plus, 32'h4);
      applyStimulus();
      checkOutput("seq4", PC_out, 32'h4);
      applyStimulus();
      checkOutput("seq8", PC_out, 32'h8);

      // Jump
      JMP = 1'b1; JMP_TARGET = 32'h100;
      applyStimulus();
      checkState("jmp", 32'h100, 1'b0, 1'b1, 1'b0);
      JMP = 1'b0;
      applyStimulus();
      checkState("jmp.next", 32'h104, 1'b0, 1'b0, 1'b0);
      JMP = 1'b1; JMP_TARGET = 32'h20;
      applyStimulus();
      checkOutput("jmp20", PC_out, 32'h20);

      // Stalled branch held for three cycles
      JMP = 1'b0; STALL = 1'b1; BR_TAKEN = 1'b1; BR_TARGET = 32'h400;
      applyStimulus();
      checkState("stall1", 32'h20, 1'b1, 1'b0, 1'b0);
      BR_TAKEN = 1'b0;
      applyStimulus();
      checkState("stall2", 32'h20, 1'b1, 1'b0, 1'b0);
      applyStimulus();
      checkState("stall3", 32'h20, 1'b1, 1'b0, 1'b0);
      STALL = 1'b0;
      applyStimulus();
      checkState("stall.apply", 32'h400, 1'b0, 1'b1, 1'b0);
      applyStimulus();
      checkState("stall.after", 32'h404, 1'b0, 1'b0, 1'b0);

      // JMP never overwrites a pending BR; same-cycle JMP at apply is dropped
      STALL = 1'b1; BR_TAKEN = 1'b1; BR_TARGET = 32'h400;
      applyStimulus();
      BR_TAKEN = 1'b0; JMP = 1'b1; JMP_TARGET = 32'h800;
      applyStimulus();
      checkState("prio.hold", 32'h404, 1'b1, 1'b0, 1'b0);
      STALL = 1'b0;
      applyStimulus();
      checkState("prio.apply", 32'h400, 1'b0, 1'b1, 1'b0);
      JMP = 1'b0;
      applyStimulus();
      checkOutput("prio.after", PC_out, 32'h404);

      // A pending JMP is overwritten by a later stalled JMP
      STALL = 1'b1; JMP = 1'b1; JMP_TARGET = 32'h900;
      applyStimulus();
      JMP_TARGET = 32'h940;
      applyStimulus();
      STALL = 1'b0; JMP = 1'b0;
      applyStimulus();
      checkState("jmp.overwrite", 32'h940, 1'b0, 1'b1, 1'b0);

      // Unstalled branch squashes a pending jump
      STALL = 1'b1; JMP = 1'b1; JMP_TARGET = 32'h900;
      applyStimulus();
      STALL = 1'b0; JMP = 1'b0; BR_TAKEN = 1'b1; BR_TARGET = 32'h600;
      applyStimulus();
      checkState("br.override", 32'h600, 1'b0, 1'b1, 1'b0);
      BR_TAKEN = 1'b0;

      // Exception during stall wins and discards the pending entry
      STALL = 1'b1; BR_TAKEN = 1'b1; BR_TARGET = 32'h400;
      applyStimulus();
      checkState("exc.pre", 32'h600, 1'b1, 1'b0, 1'b0);
      BR_TAKEN = 1'b0; EXC = 1'b1;
      applyStimulus();
      checkState("exc", 32'h180, 1'b0, 1'b1, 1'b0);
      EXC = 1'b0; STALL = 1'b0;
      applyStimulus();
      checkState("exc.after", 32'h184, 1'b0, 1'b0, 1'b0);

      // Misaligned branch, then misaligned pending jump
      BR_TAKEN = 1'b1; BR_TARGET = 32'h402;
      applyStimulus();
      checkState("mis.br", 32'h180, 1'b0, 1'b1, 1'b1);
      BR_TAKEN = 1'b0;
      applyStimulus();
      checkState("mis.after", 32'h184, 1'b0, 1'b0, 1'b0);
      STALL = 1'b1; JMP = 1'b1; JMP_TARGET = 32'h203;
      applyStimulus();
      checkState("mis.capture", 32'h184, 1'b1, 1'b0, 1'b0);
      STALL = 1'b0; JMP = 1'b0;
      applyStimulus();
      checkState("mis.pend", 32'h180, 1'b0, 1'b1, 1'b1);
      checkOutput("mis.plus", PC_plus, 32'h184);

      // Mid-operation reset discards a pending redirect
      STALL = 1'b1; BR_TAKEN = 1'b1; BR_TARGET = 32'h700;
      applyStimulus();
      checkOutput("rst.pend", {31'd0, PENDING}, 32'd1);
      RST = 1'b1; STALL = 1'b0; BR_TAKEN = 1'b0;
      applyStimulus();
      checkState("rst.mid", 32'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("rst.mid.valid", {31'd0, PC_valid}, 32'd0);
      RST = 1'b0;
      applyStimulus();
      checkState("rst.release", 32'h0, 1'b0, 1'b0, 1'b0);
      applyStimulus();
      checkState("rst.seq", 32'h4, 1'b0, 1'b0, 1'b0);

      // 8-bit instance: sequential wrap from 0xFC to 0x00
      rst8 = 1'b0;
      applyStimulus();
      checkOutput("w8.first", {24'd0, pc8}, 32'h0);
      jmp8 = 1'b1; jmp_target8 = 8'hF8;
      applyStimulus();
      checkOutput("w8.jmp", {24'd0, pc8}, 32'hF8);
      jmp8 = 1'b0;
      applyStimulus();
      checkOutput("w8.fc", {24'd0, pc8}, 32'hFC);
      checkOutput("w8.plus", {24'd0, pc_plus8}, 32'h00);
      applyStimulus();
      checkOutput("w8.wrap", {24'd0, pc8}, 32'h00);
      checkOutput("w8.redirect", {31'd0, redirect8}, 32'd0);
      checkOutput("w8.pending", {31'd0, pending8}, 32'd0);
      checkOutput("w8.misalign", {31'd0, misalign8}, 32'd0);
      checkOutput("w8.valid", {31'd0, valid8}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised successor to the fetch-stage program counter.
- Generates the instruction fetch address each cycle. Selects among sequential increment, jump, branch redirect and exception vector.
- Supports pipeline stall. A redirect that arrives while stalled is held in a pending register and applied after the stall releases.
- Detects misaligned targets. Sits at the head of the IF stage and feeds instruction-memory address and the IF/ID PC+4 field.

Parameters:
- DATA_SIZE, 32, PC width in bits.
- INSTR_BYTES, 4, increment per sequential fetch; must be a power of two.
- RESET_VECTOR, 32'h0000_0000, PC value loaded while RST is high.
- EXC_VECTOR, 32'h0000_0180, PC value loaded on exception or misaligned redirect.

Ports:
- CLK, input, 1, clock; all state updates on the rising edge.
- RST, input, 1, synchronous, active-high reset.
- STALL, input, 1, high = hold PC (hazard unit).
- JMP, input, 1, jump request from ID.
- JMP_TARGET, input, DATA_SIZE, jump target address.
- BR_TAKEN, input, 1, taken branch resolved in EX.
- BR_TARGET, input, DATA_SIZE, branch target address.
- EXC, input, 1, exception request.
- PC_out, output, DATA_SIZE, current fetch address.
- PC_plus, output, DATA_SIZE, PC_out + INSTR_BYTES; combinational from PC_out.
- PC_valid, output, 1, PC_out is a real fetch; low during the reset cycle.
- REDIRECT, output, 1, one-cycle pulse: PC_out was loaded from a non-sequential source on the last edge.
- MISALIGN, output, 1, one-cycle pulse: a jump/branch target was misaligned and was replaced by EXC_VECTOR.
- PENDING, output, 1, a redirect is held in the pending register.

Behaviour:
- Reset: synchronous, active-high, on the rising edge with RST=1.
  - PC_out=RESET_VECTOR; PC_valid=0; REDIRECT=0; MISALIGN=0; PENDING=0.
  - Pending register is cleared.
  - First edge with RST=0 keeps PC_out=RESET_VECTOR (no increment) and sets PC_valid=1.
  - RST asserted mid-operation discards any pending redirect.
- Source priority, evaluated each edge: EXC > BR_TAKEN > pending > JMP > sequential.
- EXC:
  - Always taken, even when STALL=1.
  - PC_out<=EXC_VECTOR; clears pending; REDIRECT=1.
- STALL=1 without EXC:
  - PC_out holds.
  - If BR_TAKEN or JMP is asserted, capture {kind,target} into the pending register; PENDING=1 from the next cycle.
  - Capture rule: BR overwrites any pending entry. JMP overwrites only an empty or JMP entry; it never overwrites a pending BR.
- STALL=0, no EXC, no BR_TAKEN, pending valid:
  - PC_out<=pending target; pending cleared; REDIRECT=1.
  - A JMP asserted in the same cycle is dropped; the pending entry is older.
- STALL=0, BR_TAKEN while pending valid: BR_TARGET is used and pending is cleared, because a newer branch squashes older work.
- Sequential: PC_out<=PC_out+INSTR_BYTES, modulo 2^DATA_SIZE; wraps from all-ones region to 0 with no flag.
- Alignment check:
  - Applies to every jump/branch/pending target at the moment it is applied.
  - If target[log2(INSTR_BYTES)-1:0]!=0, load EXC_VECTOR instead, with MISALIGN=1 and REDIRECT=1.
  - Not checked at capture time.
- FSM, 2 states:
  - IDLE to HELD on capture during stall.
  - HELD to IDLE on apply, on EXC, on a BR_TAKEN override, or on RST.
  - HELD with STALL=1 remains HELD (with overwrite per the capture rule).
- Latency: one edge from request to new PC_out. A stalled request is applied on the first edge with STALL=0.

Decomposition:
- Shared package (pipe_pkg): REDIRECT_KIND encoding (NONE, JMP, BR), INSTR_BYTES and EXC_VECTOR defaults shared with the hazard unit and CP0.
- One natural sub-module: pc_redirect_hold. It holds the pending register, capture/overwrite rule and the IDLE/HELD FSM. The top level does the priority mux, increment and alignment check.

Test Plan:
1. Reset and run: RST=1 for 2 cycles, then 0.
   - Expect PC_out=0x0, PC_valid 0→1.
   - Then 0x0, 0x4, 0x8, 0xC on successive edges.
2. Jump:
   - At PC=0x8, JMP=1, JMP_TARGET=0x100 → next PC_out=0x100, REDIRECT pulse.
   - Following edge gives 0x104.
3. Stalled branch:
   - STALL=1 for 3 cycles at PC=0x20; BR_TAKEN=1, BR_TARGET=0x400 in the first cycle.
   - PC_out holds 0x20 and PENDING=1.
   - First edge after STALL=0 gives 0x400, PENDING=0.
4. Priority during stall:
   - STALL=1, BR_TAKEN→0x400, then next cycle JMP→0x800 → pending keeps 0x400 and applies 0x400.
   - Repeat with EXC=1 during stall → PC_out=0x180 immediately, PENDING=0.
5. Misaligned target: BR_TAKEN=1, BR_TARGET=0x402 → PC_out=0x180, MISALIGN and REDIRECT pulse for one cycle.
6. Wrap and mid-op reset:
   - DATA_SIZE=8, INSTR_BYTES=4, PC=0xFC, sequential → 0x00.
   - Capture pending, then RST=1 → PC_out=RESET_VECTOR, PENDING=0, and no stale redirect after release.
